// File: rtl/cic_decimator_pkg.sv
// rtl/cic_decimator_pkg.sv - shared FSM state type and width derivations for the CIC decimator
package cic_decimator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // One bit of headroom on top of ORDER*log2(OSR) keeps the last stage from wrapping.
  function automatic int calc_acc_w(input int order, input int osr);
    return order * log2_ceil(osr) + 1;
  endfunction

  function automatic int calc_cnt_w(input int osr);
    return log2_ceil(osr) + 1;
  endfunction

endpackage

// File: rtl/cic_serializer.sv
// rtl/cic_serializer.sv - MSB-first load/shift register for serial readout of the result
module cic_serializer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  output logic         serial_out
);

  logic [W-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = load_data;
    end else if (shift) begin
      sreg_d = sreg_q << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign serial_out = sreg_q[W-1];

endmodule

// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - CIC integrate-and-dump decimator for a 1-bit modulator stream
module cic_decimator
  import cic_decimator_pkg::*;
#(
  parameter int OSR   = 512,
  parameter int ORDER = 2,
  parameter int OUT_W = 12,
  parameter int SHIFT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             data_in,
  input  logic             shift,
  output logic             busy,
  output logic [OUT_W-1:0] data_out,
  output logic             data_valid,
  output logic             sat,
  output logic             serial_data_out
);

  localparam int ACC_W = calc_acc_w(ORDER, OSR);
  localparam int CNT_W = calc_cnt_w(OSR);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(OSR - 1);
  localparam logic [63:0] OUT_MAX = (64'd1 << OUT_W) - 64'd1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] integ_q [ORDER];
  logic [ACC_W-1:0] integ_d [ORDER];
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             sat_q, sat_d;
  logic [63:0]      scaled;
  logic             clip;
  logic [OUT_W-1:0] result;
  logic             load;

  always_comb begin
    scaled = 64'(integ_q[ORDER-1]) >> SHIFT;
    clip   = scaled > OUT_MAX;
    result = clip ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    integ_d    = integ_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    sat_d      = sat_q;
    load       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start || cont) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          for (int i = 0; i < ORDER; i++) integ_d[i] = '0;
        end
      end
      ST_RUN: begin
        // Later stages add the already-updated value of the stage before them.
        integ_d[0] = integ_q[0] + ACC_W'(data_in);
        for (int i = 1; i < ORDER; i++) integ_d[i] = integ_q[i] + integ_d[i-1];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SAMPLE) state_d = ST_DONE;
      end
      ST_DONE: begin
        data_out_d = result;
        sat_d      = clip;
        valid_d    = 1'b1;
        load       = 1'b1;
        if (cont) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          for (int i = 0; i < ORDER; i++) integ_d[i] = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      for (int i = 0; i < ORDER; i++) integ_q[i] <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      integ_q    <= integ_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      sat_q      <= sat_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign sat        = sat_q;

  cic_serializer #(
    .W(OUT_W)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (result),
    .shift     (shift),
    .serial_out(serial_data_out)
  );

endmodule
